// File: rtl/mem_stage_lsu.sv
// RV32I MEM stage: turns EX results into data-memory bus accesses and registers the
// MEM/WB fields. It holds the upstream stage while a memory access is outstanding.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic        RegWEn_in,
  input  logic [1:0]  WBSel_in,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ALU_Result_in,
  input  logic [31:0] DataB_in,
  input  logic [31:0] pcPlus4_in,
  input  logic [4:0]  AddrD_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        RegWEn_out,
  output logic [1:0]  WBSel_out,
  output logic [31:0] DataR_out,
  output logic [31:0] ALU_Result_out,
  output logic [31:0] pcPlus4_out,
  output logic [4:0]  AddrD_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    off;
  logic          is_mem, aligned, acc, misaligned, abort;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_data;

  assign off        = ALU_Result_in[1:0];
  assign is_mem     = valid_in & (mem_rd_in | mem_wr_in);
  assign misaligned = is_mem & ~aligned;
  assign acc        = is_mem & aligned;

  always_comb begin
    case (funct3_in[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~off[0];
      default: aligned = (off == 2'b00);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request fields come straight from the inputs; stall_out keeps them stable during WAIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dmem_req  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        dmem_req = acc;
        if (acc && !dmem_ready) begin
          state_nxt = WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_nxt = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LIM) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset_n) begin
      dmem_req = 1'b0;
      abort    = 1'b0;
    end
  end

  assign stall_out = dmem_req & ~dmem_ready & ~abort;
  assign dmem_we   = dmem_req & mem_wr_in;
  assign dmem_addr = {ALU_Result_in[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = DataB_in;
    if (mem_wr_in) begin
      case (funct3_in[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << off;
          dmem_wdata = {4{DataB_in[7:0]}};
        end
        2'b01: begin
          dmem_be    = off[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{DataB_in[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // funct3[2] selects zero extension for BU/HU.
  always_comb begin
    ld_b = dmem_rdata[{off, 3'b000} +: 8];
    ld_h = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_in[1:0])
      2'b00:   ld_data = {{24{ld_b[7] & ~funct3_in[2]}}, ld_b};
      2'b01:   ld_data = {{16{ld_h[15] & ~funct3_in[2]}}, ld_h};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      RegWEn_out     <= 1'b0;
      WBSel_out      <= '0;
      DataR_out      <= '0;
      ALU_Result_out <= '0;
      pcPlus4_out    <= '0;
      AddrD_out      <= '0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      RegWEn_out     <= 1'b0;
      WBSel_out      <= '0;
      DataR_out      <= '0;
      ALU_Result_out <= '0;
      pcPlus4_out    <= '0;
      AddrD_out      <= '0;
      misaligned_out <= 1'b0;
      bus_err_out    <= abort;
      if (!stall_out && !abort && valid_in) begin
        RegWEn_out     <= RegWEn_in & ~misaligned;
        WBSel_out      <= WBSel_in;
        DataR_out      <= (mem_rd_in & aligned) ? ld_data : 32'h0;
        ALU_Result_out <= ALU_Result_in;
        pcPlus4_out    <= pcPlus4_in;
        AddrD_out      <= AddrD_in;
        misaligned_out <= misaligned;
      end
    end
  end

endmodule
